// File: rtl/eth_axil_pkg.sv
// eth_axil_pkg: shared response codes, FSM state types and register-index helpers
package eth_axil_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
  function automatic int status_idx(input int num_regs);
    return num_regs;
  endfunction
  function automatic int irq_stat_idx(input int num_regs);
    return num_regs + 1;
  endfunction
  function automatic int irq_mask_idx(input int num_regs);
    return num_regs + 2;
  endfunction
endpackage

// File: rtl/eth_axil_irq_ctrl.sv
// eth_axil_irq_ctrl: sticky IRQ status with write-1-to-clear, mask and registered irq output
module eth_axil_irq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] events,
  input  logic       clr,
  input  logic [7:0] clr_bits,
  input  logic       mask_we,
  input  logic [7:0] mask_bits,
  output logic [7:0] stat,
  output logic [7:0] mask,
  output logic       irq
);
  logic [7:0] ev_q;
  // a new event edge is OR-ed in after the clear, so set beats clear on the same bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ev_q <= '0;
      stat <= '0;
      mask <= '0;
      irq <= 1'b0;
    end else begin
      ev_q <= events;
      stat <= (stat & ~(clr ? clr_bits : 8'h00)) | (events & ~ev_q);
      mask <= mask_we ? mask_bits : mask;
      irq <= |(stat & mask);
    end
endmodule

// File: rtl/eth_axil_reg_slave.sv
// eth_axil_reg_slave: AXI4-Lite register file for the Ethernet core (RW config, status word)
// Define ETH_AXIL_IRQ_EN to add IRQ_STAT/IRQ_MASK registers with irq_event_i/irq_o.
module eth_axil_reg_slave
  import eth_axil_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0] cfg_o,
  output logic [NUM_REGS-1:0]        cfg_wr_o,
  input  logic [DATA_W-1:0]          status_i
`ifdef ETH_AXIL_IRQ_EN
  ,
  input  logic [7:0]                 irq_event_i,
  output logic                       irq_o
`endif
);
  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] STAT_IDX = IDX_W'(status_idx(NUM_REGS));
`ifdef ETH_AXIL_IRQ_EN
  localparam logic [IDX_W-1:0] IRQS_IDX = IDX_W'(irq_stat_idx(NUM_REGS));
  localparam logic [IDX_W-1:0] IRQM_IDX = IDX_W'(irq_mask_idx(NUM_REGS));
  logic [7:0] irq_stat, irq_mask;
`endif
  wr_state_t wr_state;
  rd_state_t rd_state;
  logic aw_held, w_held, aw_hs, w_hs, wr_go, wr_ok;
  logic [IDX_W-1:0] aw_idx_q, wr_idx, rd_idx;
  logic [DATA_W-1:0] wdata_q, wr_data, rd_data;
  logic [DATA_W/8-1:0] wstrb_q, wr_strb;
  logic [1:0] rd_resp;
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID & S_AXI_WREADY;
  // commit on the edge where the second of AW/W arrives, using live bus values for whichever is new
  assign wr_go = (wr_state == WR_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
  assign wr_idx = aw_held ? aw_idx_q : S_AXI_AWADDR[ADDR_W-1:2];
  assign wr_data = w_held ? wdata_q : S_AXI_WDATA;
  assign wr_strb = w_held ? wstrb_q : S_AXI_WSTRB;
  assign rd_idx = S_AXI_ARADDR[ADDR_W-1:2];
`ifdef ETH_AXIL_IRQ_EN
  assign wr_ok = (wr_idx < STAT_IDX) | (wr_idx == IRQS_IDX) | (wr_idx == IRQM_IDX);
  eth_axil_irq_ctrl u_irq (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .events   (irq_event_i),
    .clr      (wr_go && wr_idx == IRQS_IDX && wr_strb[0]),
    .clr_bits (wr_data[7:0]),
    .mask_we  (wr_go && wr_idx == IRQM_IDX && wr_strb[0]),
    .mask_bits(wr_data[7:0]),
    .stat     (irq_stat),
    .mask     (irq_mask),
    .irq      (irq_o)
  );
`else
  assign wr_ok = wr_idx < STAT_IDX;
`endif
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      wr_state <= WR_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= RESP_OKAY;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (wr_state == WR_RESP) begin
      if (S_AXI_BREADY) begin
        wr_state <= WR_IDLE;
        S_AXI_BVALID <= 1'b0;
        S_AXI_AWREADY <= 1'b1;
        S_AXI_WREADY <= 1'b1;
      end
    end else if (wr_go) begin
      wr_state <= WR_RESP;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b1;
      S_AXI_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      aw_held <= 1'b0;
      w_held <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx_q <= S_AXI_AWADDR[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      S_AXI_AWREADY <= !(aw_held | aw_hs);
      S_AXI_WREADY <= !(w_held | w_hs);
    end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      cfg_o <= '0;
      cfg_wr_o <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        cfg_wr_o[k] <= wr_go && wr_idx == IDX_W'(k);
        for (int b = 0; b < DATA_W / 8; b++)
          if (wr_go && wr_idx == IDX_W'(k) && wr_strb[b])
            cfg_o[k*DATA_W+8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    for (int k = 0; k < NUM_REGS; k++)
      if (rd_idx == IDX_W'(k)) begin
        rd_data = cfg_o[k*DATA_W +: DATA_W];
        rd_resp = RESP_OKAY;
      end
    if (rd_idx == STAT_IDX) begin
      rd_data = status_i;
      rd_resp = RESP_OKAY;
    end
`ifdef ETH_AXIL_IRQ_EN
    if (rd_idx == IRQS_IDX) begin
      rd_data = DATA_W'(irq_stat);
      rd_resp = RESP_OKAY;
    end
    if (rd_idx == IRQM_IDX) begin
      rd_data = DATA_W'(irq_mask);
      rd_resp = RESP_OKAY;
    end
`endif
  end
  // read data is captured from the pre-edge register values, so a same-edge write is not visible
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      rd_state <= RD_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (rd_state == RD_RESP) begin
      if (S_AXI_RREADY) begin
        rd_state <= RD_IDLE;
        S_AXI_RVALID <= 1'b0;
        S_AXI_ARREADY <= 1'b1;
      end
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rd_state <= RD_RESP;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA <= rd_data;
      S_AXI_RRESP <= rd_resp;
    end else begin
      S_AXI_ARREADY <= 1'b1;
    end
endmodule

// File: tb/tb_eth_axil_reg_slave.sv
// tb_eth_axil_reg_slave: scoreboard bench for the AXI4-Lite register slave
// Define ETH_AXIL_IRQ_EN for both RTL and bench to exercise the IRQ registers.
module tb_eth_axil_reg_slave;
  import eth_axil_pkg::*;
  logic ACLK = 0, ARESETN = 0;
  logic [5:0] awaddr = 0, araddr = 0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [31:0] wdata = 0, status = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [127:0] cfg;
  logic [3:0] cfg_wr;
`ifdef ETH_AXIL_IRQ_EN
  logic [7:0] irq_ev = 0;
  logic irq;
`endif
  int total = 0, bad = 0, pulses = 0, pulses0 = 0;
  logic [1:0] exp_b[$];
  logic [33:0] exp_r[$];
  always #5 ACLK = ~ACLK;
  eth_axil_reg_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .cfg_o(cfg), .cfg_wr_o(cfg_wr), .status_i(status)
`ifdef ETH_AXIL_IRQ_EN
    , .irq_event_i(irq_ev), .irq_o(irq)
`endif
  );
  always @(negedge ACLK)
    if (ARESETN) begin
      pulses <= pulses + $countones(cfg_wr);
      pulses0 <= pulses0 + int'(cfg_wr[0]);
    end
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, bad=%0d", bad);
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er,
                    input int aw_dly, input int w_dly, input int hold, output int lat);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int n = 0;
    logic [1:0] eb;
    exp_b.push_back(er);
    awaddr = a; wdata = d; wstrb = s; bready = (hold == 0);
    while (!(aw_done && w_done) && n < 30) begin
      awvalid = !aw_done && n >= aw_dly;
      wvalid = !w_done && n >= w_dly;
      hs_aw = awvalid && awready;
      hs_w = wvalid && wready;
      tick();
      aw_done |= hs_aw;
      w_done |= hs_w;
      n++;
    end
    awvalid = 0; wvalid = 0;
    chk("wr_handshake", {aw_done, w_done}, 2'b11);
    lat = 1;
    while (!bvalid && lat < 20) begin tick(); lat++; end
    for (int i = 0; i < hold; i++) begin
      chk("b_hold", {bvalid, bresp, awready, wready}, {1'b1, er, 2'b00});
      tick();
    end
    bready = 1;
    eb = exp_b.pop_front();
    chk("bvalid", bvalid, 1'b1);
    chk("bresp", bresp, eb);
    tick();
    chk("b_done", {bvalid, awready, wready}, 3'b011);
  endtask
  task automatic rd(input logic [5:0] a, input logic [31:0] d, input logic [1:0] er, input int hold);
    int n = 0;
    logic [33:0] e;
    exp_r.push_back({er, d});
    araddr = a; arvalid = 1; rready = (hold == 0);
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    for (int i = 0; i < hold; i++) begin
      chk("r_hold", {rvalid, rresp, rdata, arready}, {1'b1, er, d, 1'b0});
      tick();
    end
    rready = 1;
    e = exp_r.pop_front();
    chk("rvalid", rvalid, 1'b1);
    chk("rresp", rresp, e[33:32]);
    chk("rdata", rdata, e[31:0]);
    tick();
    chk("r_done", {rvalid, arready}, 2'b01);
  endtask
  initial begin
    int lat, p;
    logic [33:0] e;
    #2;
    chk("rst_out", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, cfg_wr}, 0);
    chk("rst_cfg", cfg, 0);
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1;
    chk("rst_rdy_low", {awready, wready, arready}, 3'b000);
    tick();
    chk("rst_rdy_high", {awready, wready, arready}, 3'b111);
    // T1: back-to-back writes then read-back
    for (int i = 0; i < 4; i++) begin
      wr(6'(4 * i), 32'(i + 1), 4'hF, RESP_OKAY, 0, 0, 0, lat);
      chk("b_latency", lat, 1);
    end
    for (int i = 0; i < 4; i++) rd(6'(4 * i), 32'(i + 1), RESP_OKAY, 0);
    chk("cfg_t1", cfg, {32'h4, 32'h3, 32'h2, 32'h1});
    // same-edge read and write to reg1: read sees old value
    exp_b.push_back(RESP_OKAY);
    exp_r.push_back({RESP_OKAY, 32'h2});
    awaddr = 6'h04; wdata = 32'h55; wstrb = 4'hF; araddr = 6'h04;
    awvalid = 1; wvalid = 1; arvalid = 1;
    chk("idle_rdy", {awready, wready, arready}, 3'b111);
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("b_same", {bvalid, bresp}, {1'b1, exp_b.pop_front()});
    e = exp_r.pop_front();
    chk("r_same", {rvalid, rresp, rdata}, {1'b1, e});
    tick();
    rd(6'h04, 32'h55, RESP_OKAY, 0);
    // T2: AW before W, then W before AW
    p = pulses;
    wr(6'h08, 32'hCAFE0008, 4'hF, RESP_OKAY, 0, 3, 0, lat);
    tick();
    chk("single_b_aw1st", bvalid, 1'b0);
    chk("pulse_aw1st", pulses - p, 1);
    chk("lat_aw1st", lat, 1);
    p = pulses;
    wr(6'h0C, 32'hBEEF000C, 4'hF, RESP_OKAY, 3, 0, 0, lat);
    tick();
    chk("single_b_w1st", bvalid, 1'b0);
    chk("pulse_w1st", pulses - p, 1);
    rd(6'h08, 32'hCAFE0008, RESP_OKAY, 0);
    rd(6'h0C, 32'hBEEF000C, RESP_OKAY, 0);
    // T3: partial strobes and zero strobe
    wr(6'h00, 32'hFFFFFFFF, 4'hF, RESP_OKAY, 0, 0, 0, lat);
    p = pulses0;
    wr(6'h00, 32'h00000000, 4'b0101, RESP_OKAY, 0, 0, 0, lat);
    chk("pulse0_once", pulses0 - p, 1);
    rd(6'h00, 32'hFF00FF00, RESP_OKAY, 0);
    p = pulses;
    wr(6'h04, 32'h12345678, 4'h0, RESP_OKAY, 0, 0, 0, lat);
    chk("pulse_strb0", pulses - p, 1);
    rd(6'h04, 32'h55, RESP_OKAY, 0);
    // T4: status, error decode, ignored low address bits
    status = 32'hA5A50001;
    rd(6'h10, 32'hA5A50001, RESP_OKAY, 0);
    p = pulses;
    wr(6'h10, 32'hDEADBEEF, 4'hF, RESP_SLVERR, 0, 0, 0, lat);
    wr(6'h3C, 32'hDEADBEEF, 4'hF, RESP_SLVERR, 0, 0, 0, lat);
    chk("pulse_err", pulses - p, 0);
    chk("cfg_after_err", cfg, {32'hBEEF000C, 32'hCAFE0008, 32'h55, 32'hFF00FF00});
    rd(6'h3C, 32'h0, RESP_SLVERR, 0);
    rd(6'h05, 32'h55, RESP_OKAY, 0);
    rd(6'h1C, 32'h0, RESP_SLVERR, 0);
`ifndef ETH_AXIL_IRQ_EN
    rd(6'h14, 32'h0, RESP_SLVERR, 0);
    wr(6'h18, 32'h1, 4'hF, RESP_SLVERR, 0, 0, 0, lat);
`endif
    // T5: back-pressure on B and R
    wr(6'h00, 32'h11111111, 4'hF, RESP_OKAY, 0, 0, 5, lat);
    rd(6'h00, 32'h11111111, RESP_OKAY, 5);
    rd(6'h3C, 32'h0, RESP_SLVERR, 5);
`ifdef ETH_AXIL_IRQ_EN
    // T6: interrupt status, mask and clear
    wr(6'h18, 32'h01, 4'hF, RESP_OKAY, 0, 0, 0, lat);
    chk("irq_idle", irq, 1'b0);
    irq_ev = 8'h01;
    tick();
    irq_ev = 8'h00;
    tick();
    chk("irq_set", irq, 1'b1);
    rd(6'h14, 32'h01, RESP_OKAY, 0);
    wr(6'h14, 32'h01, 4'hF, RESP_OKAY, 0, 0, 0, lat);
    tick();
    chk("irq_clr", irq, 1'b0);
    rd(6'h14, 32'h00, RESP_OKAY, 0);
    irq_ev = 8'h01;
    wr(6'h14, 32'h01, 4'hF, RESP_OKAY, 0, 0, 0, lat);
    irq_ev = 8'h00;
    tick();
    chk("irq_set_wins", irq, 1'b1);
    rd(6'h14, 32'h01, RESP_OKAY, 0);
    rd(6'h18, 32'h01, RESP_OKAY, 0);
`endif
    chk("sb_empty", {32'(exp_b.size()), 32'(exp_r.size())}, 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
